tlb_v2: RTL
===========

# tlb_v2

Parametrised second-generation joint TLB for the MIPS core: fully associative, TLBNUM entries of even/odd page pairs, two search ports (fetch and data) with registered one-cycle results, and an explicit per-entry exist bit cleared at reset. Adds three things the first-generation TLB lacks:
- a hardware Random index counter honouring CP0 Wired, for TLBWR;
- a multi-cycle invalidate sweep (all / non-global / by-ASID) with busy/done handshake;
- multiple-match detection.

Sits between the CP0 TLB-instruction logic and the IF/MEM address-translation stages.

## Interface
- TLBNUM, 16, entry count; power of two, 4..64; IW = $clog2(TLBNUM)
- ASID_W, 8, ASID width
- PFN_W, 20, physical frame number width
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- s0_req  in  1  search request, port 0
- s0_vpn2 / s0_odd_page / s0_asid  in  19 / 1 / ASID_W  search key (vaddr[31:13], vaddr[12], EntryHi.ASID)
- s0_rvalid  out  1  result valid, one cycle after s0_req
- s0_found  out  1  at least one entry matched
- s0_multi  out  1  two or more entries matched
- s0_index  out  IW  lowest matching index
- s0_pfn / s0_c / s0_d / s0_v  out  PFN_W / 3 / 1 / 1  page fields of the selected half of the lowest match
- s1_*  same set as s0_*, independent port 1
- we  in  1  write entry
- wr_random  in  1  with we: target = random instead of w_index
- w_index  in  IW  write target
- w_vpn2 / w_asid / w_g  in  19 / ASID_W / 1  EntryHi fields and G
- w_pfn0 / w_c0 / w_d0 / w_v0  in  PFN_W / 3 / 1 / 1  EntryLo0 fields
- w_pfn1 / w_c1 / w_d1 / w_v1  in  PFN_W / 3 / 1 / 1  EntryLo1 fields
- r_index  in  IW  read index
- r_e  out  1  exist bit of entry r_index; other r_* fields as the w_* set, combinational
- cp0_wired  in  IW  CP0 Wired value
- random  out  IW  current Random index
- inv_req  in  1  start invalidate sweep
- inv_op  in  2  0 = all, 1 = non-global (G=0), 2 = G=0 and ASID == inv_asid, 3 = G=1 or ASID == inv_asid
- inv_asid  in  ASID_W  ASID operand, sampled with inv_req
- inv_busy  out  1  sweep in progress
- inv_done  out  1  one-cycle pulse at sweep end

## Operation
- Match on entry i: E[i] && vpn2 == tlb_vpn2[i] && (tlb_g[i] || tlb_asid[i] == key asid).
- Result fields:
  - odd_page selects the pfn1/c1/d1/v1 half.
  - With no match, index/pfn/c/d/v = 0.
  - With several matches, the lowest index wins and s_multi = 1.
- Result registers update only when s_req = 1; otherwise they hold. s_rvalid = registered s_req.
- Write:
  - Writes all fields of the target entry and sets E = 1.
  - Target = random if wr_random, else w_index.
- Random counter:
  - Decrements by one every cycle.
  - When at cp0_wired it reloads TLBNUM-1 the next cycle.
  - If cp0_wired > random (Wired raised), it reloads TLBNUM-1.
  - If cp0_wired = TLBNUM-1, random stays TLBNUM-1.
- Invalidate FSM states: IDLE, SWEEP, DONE.
  - IDLE, inv_req = 1: latch inv_op/inv_asid, ptr = 0, go to SWEEP.
  - SWEEP: each cycle, clear E[ptr] if entry ptr satisfies inv_op; ptr++. When ptr = TLBNUM-1, go to DONE.
  - DONE: inv_done = 1 for one cycle, then IDLE.
  - inv_req is ignored while busy.
  - A we to the same index as ptr in the same cycle wins: the entry is written and E = 1.
- Reset clears all E bits, result registers and the FSM. tlb_* field storage is not reset.

## Timing
- Reset values: s*_rvalid 0, s*_found 0, s*_multi 0, s*_index/pfn/c/d/v 0, random TLBNUM-1, inv_busy 0, inv_done 0.
- Search latency is 1 cycle.
- A search sampled on the same edge as a write sees pre-write contents; the next cycle sees the new contents.
- Read port is combinational and reflects a write from the following cycle on.
- inv_busy is 1 from the cycle after an accepted inv_req through the DONE cycle inclusive.
- Sweep length is TLBNUM cycles plus 1 DONE cycle.
- Searches during the sweep are legal and see the partially cleared state.
- resetn asserted mid-sweep: immediate return to IDLE, all E = 0, no inv_done.

## Test plan
- Reset, then search any key on both ports: s*_rvalid = 1 one cycle later, found = 0, index = 0; random = 15 (TLBNUM = 16).
- Write index 3: vpn2 = 0x12345, asid = 5, g = 0, pfn1 = 0xABCDE, v1 = 1. Search vpn2 = 0x12345, odd = 1, asid = 5: found = 1, index = 3, pfn = 0xABCDE, v = 1. Same key with asid = 6: found = 0.
- Write entries 2 and 7 with an identical key (g = 1). Search: found = 1, index = 2, multi = 1.
- Random sequence: cp0_wired = 4, observe random 15, 14, …, 4, 15. Then wr_random write when random = 9: r_index 9 returns the written data, r_e = 1.
- Invalidate: fill 16 entries with g alternating and asid = 5 or 6. Issue inv_op = 2, inv_asid = 5: inv_busy for 17 cycles, one inv_done pulse, only G=0/ASID=5 entries have r_e = 0. Also inject we to ptr's index during the sweep: that entry keeps E = 1.
- Assert resetn mid-sweep (cycle 6): inv_busy = 0 immediately, no inv_done, all r_e = 0.

Source files
------------

// File: rtl/tlb_v2.sv
// tlb_v2: fully associative joint TLB of even/odd page pairs.
// Two independent search ports with one-cycle registered results and
// multiple-match detection, a combinational read port, a hardware Random
// index counter that honours CP0 Wired, and a multi-cycle invalidate sweep
// (all / non-global / by-ASID) with a busy/done handshake.
module tlb_v2 #(
   parameter int  TLBNUM = 16,
   parameter int  ASID_W = 8,
   parameter int  PFN_W  = 20,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic              clk,
   input  logic              resetn,
   // search port 0 (fetch)
   input  logic              s0_req,
   input  logic [18:0]       s0_vpn2,
   input  logic              s0_odd_page,
   input  logic [ASID_W-1:0] s0_asid,
   output logic              s0_rvalid,
   output logic              s0_found,
   output logic              s0_multi,
   output logic [IW-1:0]     s0_index,
   output logic [PFN_W-1:0]  s0_pfn,
   output logic [2:0]        s0_c,
   output logic              s0_d,
   output logic              s0_v,
   // search port 1 (data)
   input  logic              s1_req,
   input  logic [18:0]       s1_vpn2,
   input  logic              s1_odd_page,
   input  logic [ASID_W-1:0] s1_asid,
   output logic              s1_rvalid,
   output logic              s1_found,
   output logic              s1_multi,
   output logic [IW-1:0]     s1_index,
   output logic [PFN_W-1:0]  s1_pfn,
   output logic [2:0]        s1_c,
   output logic              s1_d,
   output logic              s1_v,
   // write port
   input  logic              we,
   input  logic              wr_random,
   input  logic [IW-1:0]     w_index,
   input  logic [18:0]       w_vpn2,
   input  logic [ASID_W-1:0] w_asid,
   input  logic              w_g,
   input  logic [PFN_W-1:0]  w_pfn0,
   input  logic [2:0]        w_c0,
   input  logic              w_d0,
   input  logic              w_v0,
   input  logic [PFN_W-1:0]  w_pfn1,
   input  logic [2:0]        w_c1,
   input  logic              w_d1,
   input  logic              w_v1,
   // read port
   input  logic [IW-1:0]     r_index,
   output logic              r_e,
   output logic [18:0]       r_vpn2,
   output logic [ASID_W-1:0] r_asid,
   output logic              r_g,
   output logic [PFN_W-1:0]  r_pfn0,
   output logic [2:0]        r_c0,
   output logic              r_d0,
   output logic              r_v0,
   output logic [PFN_W-1:0]  r_pfn1,
   output logic [2:0]        r_c1,
   output logic              r_d1,
   output logic              r_v1,
   // Random / Wired
   input  logic [IW-1:0]     cp0_wired,
   output logic [IW-1:0]     random,
   // invalidate sweep
   input  logic              inv_req,
   input  logic [1:0]        inv_op,
   input  logic [ASID_W-1:0] inv_asid,
   output logic              inv_busy,
   output logic              inv_done
);

   typedef enum logic [1:0] {INV_IDLE, INV_SWEEP, INV_DONE} inv_state_e;

   localparam logic [IW-1:0] LAST = IW'(TLBNUM - 1);

   // entry storage; only the exist bits are reset
   logic [18:0]       tlb_vpn2_q [TLBNUM];
   logic [ASID_W-1:0] tlb_asid_q [TLBNUM];
   logic              tlb_g_q    [TLBNUM];
   logic [PFN_W-1:0]  tlb_pfn0_q [TLBNUM];
   logic [2:0]        tlb_c0_q   [TLBNUM];
   logic              tlb_d0_q   [TLBNUM];
   logic              tlb_v0_q   [TLBNUM];
   logic [PFN_W-1:0]  tlb_pfn1_q [TLBNUM];
   logic [2:0]        tlb_c1_q   [TLBNUM];
   logic              tlb_d1_q   [TLBNUM];
   logic              tlb_v1_q   [TLBNUM];
   logic [TLBNUM-1:0] e_q, e_d;

   logic [IW-1:0]     random_q, random_d;
   logic [IW-1:0]     w_tgt;

   // both search ports share one lookup body, indexed by port
   logic [1:0]              k_req, k_odd;
   logic [1:0][18:0]        k_vpn2;
   logic [1:0][ASID_W-1:0]  k_asid;

   logic [1:0]              hit_found, hit_multi, hit_d, hit_v;
   logic [1:0][IW-1:0]      hit_index;
   logic [1:0][PFN_W-1:0]   hit_pfn;
   logic [1:0][2:0]         hit_c;

   logic [1:0]              rvalid_q, rvalid_d, found_q, found_d, multi_q, multi_d;
   logic [1:0]              dbit_q, dbit_d, vbit_q, vbit_d;
   logic [1:0][IW-1:0]      index_q, index_d;
   logic [1:0][PFN_W-1:0]   pfn_q, pfn_d;
   logic [1:0][2:0]         c_q, c_d;

   // invalidate FSM state
   inv_state_e        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [1:0]        op_q, op_d;
   logic [ASID_W-1:0] iasid_q, iasid_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              sweep_hit;

   assign k_req  = {s1_req, s0_req};
   assign k_odd  = {s1_odd_page, s0_odd_page};
   assign k_vpn2 = {s1_vpn2, s0_vpn2};
   assign k_asid = {s1_asid, s0_asid};

   assign w_tgt  = wr_random ? random_q : w_index;

   // Lookup: lowest matching index wins, any further match flags multi
   always_comb begin
      hit_found = '0;
      hit_multi = '0;
      hit_index = '0;
      hit_pfn   = '0;
      hit_c     = '0;
      hit_d     = '0;
      hit_v     = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (e_q[i] && tlb_vpn2_q[i] == k_vpn2[p] &&
                (tlb_g_q[i] || tlb_asid_q[i] == k_asid[p])) begin
               if (!hit_found[p]) begin
                  hit_found[p] = 1'b1;
                  hit_index[p] = IW'(i);
                  hit_pfn[p]   = k_odd[p] ? tlb_pfn1_q[i] : tlb_pfn0_q[i];
                  hit_c[p]     = k_odd[p] ? tlb_c1_q[i]   : tlb_c0_q[i];
                  hit_d[p]     = k_odd[p] ? tlb_d1_q[i]   : tlb_d0_q[i];
                  hit_v[p]     = k_odd[p] ? tlb_v1_q[i]   : tlb_v0_q[i];
               end else begin
                  hit_multi[p] = 1'b1;
               end
            end
         end
      end
   end

   // Result registers capture only on a request and hold otherwise
   always_comb begin
      rvalid_d = k_req;
      found_d  = found_q;
      multi_d  = multi_q;
      index_d  = index_q;
      pfn_d    = pfn_q;
      c_d      = c_q;
      dbit_d   = dbit_q;
      vbit_d   = vbit_q;
      for (int p = 0; p < 2; p++) begin
         if (k_req[p]) begin
            found_d[p] = hit_found[p];
            multi_d[p] = hit_multi[p];
            index_d[p] = hit_index[p];
            pfn_d[p]   = hit_pfn[p];
            c_d[p]     = hit_c[p];
            dbit_d[p]  = hit_d[p];
            vbit_d[p]  = hit_v[p];
         end
      end
   end

   // Search result flops
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rvalid_q <= '0;
         found_q  <= '0;
         multi_q  <= '0;
         index_q  <= '0;
         pfn_q    <= '0;
         c_q      <= '0;
         dbit_q   <= '0;
         vbit_q   <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         found_q  <= found_d;
         multi_q  <= multi_d;
         index_q  <= index_d;
         pfn_q    <= pfn_d;
         c_q      <= c_d;
         dbit_q   <= dbit_d;
         vbit_q   <= vbit_d;
      end
   end

   // Random decrements toward Wired; at or below Wired it reloads the top
   // index (Wired = TLBNUM-1 therefore pins it at TLBNUM-1)
   always_comb begin
      if (cp0_wired >= random_q) random_d = LAST;
      else                       random_d = random_q - IW'(1);
   end

   // Random counter flop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) random_q <= LAST;
      else         random_q <= random_d;
   end

   // Does the entry under the sweep pointer satisfy the latched operation
   always_comb begin
      case (op_q)
         2'd0:    sweep_hit = 1'b1;
         2'd1:    sweep_hit = !tlb_g_q[ptr_q];
         2'd2:    sweep_hit = !tlb_g_q[ptr_q] && tlb_asid_q[ptr_q] == iasid_q;
         default: sweep_hit = tlb_g_q[ptr_q] || tlb_asid_q[ptr_q] == iasid_q;
      endcase
   end

   // Invalidate FSM next state; busy/done are registered from the next state
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      op_d    = op_q;
      iasid_d = iasid_q;
      case (state_q)
         INV_IDLE: begin
            if (inv_req) begin
               op_d    = inv_op;
               iasid_d = inv_asid;
               ptr_d   = '0;
               state_d = INV_SWEEP;
            end
         end
         INV_SWEEP: begin
            ptr_d = ptr_q + IW'(1);
            if (ptr_q == LAST) state_d = INV_DONE;
         end
         INV_DONE: state_d = INV_IDLE;
         default:  state_d = INV_IDLE;
      endcase
      busy_d = (state_d != INV_IDLE);
      done_d = (state_d == INV_DONE);
   end

   // Invalidate FSM flops
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= INV_IDLE;
         ptr_q   <= '0;
         op_q    <= '0;
         iasid_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         op_q    <= op_d;
         iasid_q <= iasid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Exist bits: sweep clears first so a same-cycle write to ptr wins
   always_comb begin
      e_d = e_q;
      if (state_q == INV_SWEEP && sweep_hit) e_d[ptr_q] = 1'b0;
      if (we) e_d[w_tgt] = 1'b1;
   end

   // Exist bit flops
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) e_q <= '0;
      else         e_q <= e_d;
   end

   // Entry field storage, written straight from the write port
   always_ff @(posedge clk) begin
      if (we) begin
         tlb_vpn2_q[w_tgt] <= w_vpn2;
         tlb_asid_q[w_tgt] <= w_asid;
         tlb_g_q[w_tgt]    <= w_g;
         tlb_pfn0_q[w_tgt] <= w_pfn0;
         tlb_c0_q[w_tgt]   <= w_c0;
         tlb_d0_q[w_tgt]   <= w_d0;
         tlb_v0_q[w_tgt]   <= w_v0;
         tlb_pfn1_q[w_tgt] <= w_pfn1;
         tlb_c1_q[w_tgt]   <= w_c1;
         tlb_d1_q[w_tgt]   <= w_d1;
         tlb_v1_q[w_tgt]   <= w_v1;
      end
   end

   assign s0_rvalid = rvalid_q[0];
   assign s0_found  = found_q[0];
   assign s0_multi  = multi_q[0];
   assign s0_index  = index_q[0];
   assign s0_pfn    = pfn_q[0];
   assign s0_c      = c_q[0];
   assign s0_d      = dbit_q[0];
   assign s0_v      = vbit_q[0];
   assign s1_rvalid = rvalid_q[1];
   assign s1_found  = found_q[1];
   assign s1_multi  = multi_q[1];
   assign s1_index  = index_q[1];
   assign s1_pfn    = pfn_q[1];
   assign s1_c      = c_q[1];
   assign s1_d      = dbit_q[1];
   assign s1_v      = vbit_q[1];

   assign r_e    = e_q[r_index];
   assign r_vpn2 = tlb_vpn2_q[r_index];
   assign r_asid = tlb_asid_q[r_index];
   assign r_g    = tlb_g_q[r_index];
   assign r_pfn0 = tlb_pfn0_q[r_index];
   assign r_c0   = tlb_c0_q[r_index];
   assign r_d0   = tlb_d0_q[r_index];
   assign r_v0   = tlb_v0_q[r_index];
   assign r_pfn1 = tlb_pfn1_q[r_index];
   assign r_c1   = tlb_c1_q[r_index];
   assign r_d1   = tlb_d1_q[r_index];
   assign r_v1   = tlb_v1_q[r_index];

   assign random   = random_q;
   assign inv_busy = busy_q;
   assign inv_done = done_q;

endmodule
